// File: rtl/trace_pkg.sv
// Shared types for the commit-trace capture buffer: record layout,
// FSM state and capture mode encodings.
package trace_pkg;

    // Timestamp width baked into the record layout; matches the default TS_W.
    localparam int unsigned TRACE_TS_W = 16;

    typedef struct packed {
        logic [TRACE_TS_W-1:0] ts;
        logic                  valid;
        logic [31:0]           pc;
        logic [31:0]           inst;
        logic                  rdv;
        logic [4:0]            rd_m;
        logic [31:0]           rd_data;
        logic                  pcv;
        logic [31:0]           pc_x;
    } trace_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        POST,
        DONE
    } trace_state_e;

    typedef enum logic {
        TM_FIFO,
        TM_RING
    } trace_mode_e;

endpackage

// File: rtl/commit_trace_buf_if.sv
// Retire-tap, control and readout signals of the commit-trace buffer.
// master = pipeline taps / debug readout side, slave = the trace buffer.
interface commit_trace_buf_if;
    import trace_pkg::*;

    // retire taps
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd_m;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;

    // capture control
    logic        mode;
    logic        arm;
    logic        trig;
    logic        stop;

    // readout
    logic        rd_valid;
    logic        rd_ready;
    trace_rec_t  rd_rec;

    modport master (
        output valid, pc, inst, rdv, rd_m, rd_data, pcv, pc_x,
        output mode, arm, trig, stop,
        output rd_ready,
        input  rd_valid, rd_rec
    );

    modport slave (
        input  valid, pc, inst, rdv, rd_m, rd_data, pcv, pc_x,
        input  mode, arm, trig, stop,
        input  rd_ready,
        output rd_valid, rd_rec
    );

endinterface

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
// Storage is not reset; validity is tracked by the controller's count.
module trace_ram
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  trace_rec_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output trace_rec_t        rdata
);

    trace_rec_t mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buf.sv
// Commit-trace capture buffer: records retire events with a cycle
// timestamp, in streaming FIFO mode or triggered ring mode with
// post-trigger capture, drained over a valid/ready readout port.
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TS_W      = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned DROP_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    commit_trace_buf_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output trace_state_e             state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(POST_TRIG + 1);

    trace_state_e      state_q,    state_d;
    trace_mode_e       mode_q,     mode_d;
    logic [AW-1:0]     wptr_q,     wptr_d;
    logic [AW-1:0]     rptr_q,     rptr_d;
    logic [CW-1:0]     count_q,    count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q,     drop_d;
    logic [TS_W-1:0]   ts_q,       ts_d;
    logic [PW-1:0]     post_q,     post_d;

    logic       capturing;
    logic       evt;
    logic       full;
    logic       rd_valid;
    logic       pop;
    logic       we;
    logic       overwrite;
    trace_rec_t wrec;
    trace_rec_t rrec;

    assign capturing = (state_q == CAPTURE) || (state_q == POST);
    assign evt       = bus.valid | bus.rdv | bus.pcv;
    assign full      = (count_q == CW'(DEPTH));
    assign rd_valid  = (count_q != '0) && ((mode_q == TM_FIFO) || (state_q == DONE));
    assign pop       = rd_valid & bus.rd_ready;

    assign wrec.ts      = TRACE_TS_W'(ts_q);
    assign wrec.valid   = bus.valid;
    assign wrec.pc      = bus.pc;
    assign wrec.inst    = bus.inst;
    assign wrec.rdv     = bus.rdv;
    assign wrec.rd_m    = bus.rd_m;
    assign wrec.rd_data = bus.rd_data;
    assign wrec.pcv     = bus.pcv;
    assign wrec.pc_x    = bus.pc_x;

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (wrec),
        .raddr (rptr_q),
        .rdata (rrec)
    );

    // Next-state: arm > stop > trig; write/drop/overwrite decision and pointer/count update
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        ts_d       = ts_q;
        post_d     = post_q;
        we         = 1'b0;
        overwrite  = 1'b0;

        if (bus.arm) begin
            state_d    = CAPTURE;
            mode_d     = bus.mode ? TM_RING : TM_FIFO;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
            ts_d       = '0;
            post_d     = '0;
        end else begin
            if (capturing) begin
                ts_d = ts_q + TS_W'(1);
            end

            if (capturing && bus.stop) begin
                state_d = DONE;
            end else if (capturing && evt) begin
                // A same-cycle pop frees a FIFO slot, so the push is still taken.
                if ((mode_q == TM_RING) || !full || pop) begin
                    we = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    if (drop_q != '1) begin
                        drop_d = drop_q + DROP_W'(1);
                    end
                end
            end

            // Ring overwrite retires the oldest record as an implicit pop.
            overwrite = we && (mode_q == TM_RING) && full;

            if (we) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop || overwrite) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (we && !pop && !overwrite) begin
                count_d = count_q + CW'(1);
            end else if (!we && pop) begin
                count_d = count_q - CW'(1);
            end

            if (capturing && !bus.stop) begin
                if (state_q == POST) begin
                    if (we) begin
                        post_d = post_q - PW'(1);
                        if (post_q == PW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end else if ((mode_q == TM_RING) && bus.trig) begin
                    state_d = POST;
                    post_d  = PW'(POST_TRIG);
                end
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= TM_FIFO;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            ts_q       <= '0;
            post_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            ts_q       <= ts_d;
            post_q     <= post_d;
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_rec   = rrec;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_q;
    assign state        = state_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf (DEPTH=4, POST_TRIG=2, DROP_W=4): a vector
// table for the FIFO overflow/drain scenario, hand-written corner
// sequences, then random stimulus checked against a queue-based model.
module tb_commit_trace_buf;
    import trace_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TS_W      = 16;
    localparam int unsigned POST_TRIG = 2;
    localparam int unsigned DROP_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    trace_state_e      state;

    commit_trace_buf_if bus();

    commit_trace_buf #(
        .DEPTH     (DEPTH),
        .TS_W      (TS_W),
        .POST_TRIG (POST_TRIG),
        .DROP_W    (DROP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    trace_rec_t   m_q[$];
    trace_state_e m_state;
    trace_mode_e  m_mode;
    logic         m_ovf;
    int unsigned  m_drop;
    int unsigned  m_ts;
    int unsigned  m_post;

    function automatic void m_reset();
        m_q.delete();
        m_state = IDLE;
        m_mode  = TM_FIFO;
        m_ovf   = 1'b0;
        m_drop  = 0;
        m_ts    = 0;
        m_post  = 0;
    endfunction

    function automatic logic m_rv();
        return (m_q.size() != 0) && (m_mode == TM_FIFO || m_state == DONE);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void m_update();
        trace_rec_t r;
        logic ev, cap, rv;
        ev = bus.valid | bus.rdv | bus.pcv;
        rv = m_rv();
        r.ts = TRACE_TS_W'(m_ts);
        r.valid = bus.valid; r.pc = bus.pc; r.inst = bus.inst;
        r.rdv = bus.rdv; r.rd_m = bus.rd_m; r.rd_data = bus.rd_data;
        r.pcv = bus.pcv; r.pc_x = bus.pc_x;
        if (bus.arm) begin
            m_q.delete();
            m_state = CAPTURE;
            m_mode  = bus.mode ? TM_RING : TM_FIFO;
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_ts    = 0;
            return;
        end
        cap = (m_state == CAPTURE) || (m_state == POST);
        if (rv && bus.rd_ready) void'(m_q.pop_front());
        if (cap && bus.stop) begin
            m_state = DONE;
        end else if (cap) begin
            if (ev) begin
                if (m_mode == TM_RING) begin
                    m_q.push_back(r);
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                end else if (m_q.size() < DEPTH) begin
                    m_q.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < (1 << DROP_W) - 1) m_drop++;
                end
            end
            if (m_state == POST) begin
                if (ev) begin
                    m_post--;
                    if (m_post == 0) m_state = DONE;
                end
            end else if (m_mode == TM_RING && bus.trig) begin
                m_state = POST;
                m_post  = POST_TRIG;
            end
        end
        if (cap) m_ts = (m_ts + 1) % (1 << TS_W);
    endfunction

    task automatic compare_model(input int unsigned cyc_no);
        string tag;
        tag = $sformatf("rnd%0d", cyc_no);
        chk({tag, ".state"},    256'(state),    256'(m_state));
        chk({tag, ".count"},    256'(count),    256'(m_q.size()));
        chk({tag, ".overflow"}, 256'(overflow), 256'(m_ovf));
        chk({tag, ".drop_cnt"}, 256'(drop_cnt), 256'(m_drop));
        chk({tag, ".rd_valid"}, 256'(bus.rd_valid), 256'(m_rv()));
        if (m_rv()) chk({tag, ".rd_rec"}, 256'(bus.rd_rec), 256'(m_q[0]));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic a, input logic md, input logic v, input logic [31:0] p,
                         input logic t, input logic s, input logic rr);
        bus.arm      = a;
        bus.mode     = md;
        bus.valid    = v;
        bus.pc       = p;
        bus.inst     = p ^ 32'hA5A5_0000;
        bus.rdv      = v;
        bus.rd_m     = p[6:2];
        bus.rd_data  = ~p;
        bus.pcv      = 1'b0;
        bus.pc_x     = p + 32'h40;
        bus.trig     = t;
        bus.stop     = s;
        bus.rd_ready = rr;
    endtask

    // One clock: drive, step the model, take the edge, settle past it.
    task automatic cyc(input logic a, input logic md, input logic v, input logic [31:0] p,
                       input logic t, input logic s, input logic rr);
        drive(a, md, v, p, t, s, rr);
        m_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         arm;
        logic         mode;
        logic         valid;
        logic [31:0]  pc;
        logic         stop;
        logic         rd_ready;
        logic [2:0]   e_count;
        trace_state_e e_state;
        logic         e_rdv;
        logic         e_ovf;
        logic [3:0]   e_drop;
        logic [31:0]  e_pc;
        logic [15:0]  e_ts;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // FIFO overflow then drain: 6 commits into 4 slots, stop, pop 4.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 3'd0, CAPTURE, 1'b0, 1'b0, 4'd0, 32'h0,   16'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 3'd1, CAPTURE, 1'b1, 1'b0, 4'd0, 32'h100, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 3'd2, CAPTURE, 1'b1, 1'b0, 4'd0, 32'h100, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 3'd3, CAPTURE, 1'b1, 1'b0, 4'd0, 32'h100, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h10C, 1'b0, 1'b0, 3'd4, CAPTURE, 1'b1, 1'b0, 4'd0, 32'h100, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h110, 1'b0, 1'b0, 3'd4, CAPTURE, 1'b1, 1'b1, 4'd1, 32'h100, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h114, 1'b0, 1'b0, 3'd4, CAPTURE, 1'b1, 1'b1, 4'd2, 32'h100, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 3'd4, DONE,    1'b1, 1'b1, 4'd2, 32'h100, 16'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 3'd3, DONE,    1'b1, 1'b1, 4'd2, 32'h104, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 3'd2, DONE,    1'b1, 1'b1, 4'd2, 32'h108, 16'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 3'd1, DONE,    1'b1, 1'b1, 4'd2, 32'h10C, 16'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 3'd0, DONE,    1'b0, 1'b1, 4'd2, 32'h0,   16'd0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state",    256'(state),        256'(IDLE));
        chk("reset.count",    256'(count),        256'(0));
        chk("reset.rd_valid", 256'(bus.rd_valid), 256'(0));
        chk("reset.overflow", 256'(overflow),     256'(0));
        chk("reset.drop_cnt", 256'(drop_cnt),     256'(0));
        reset = 1'b0;

        // vector table
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].arm, tbl[i].mode, tbl[i].valid, tbl[i].pc, 1'b0, tbl[i].stop, tbl[i].rd_ready);
            chk($sformatf("vec%0d.count", i),    256'(count),        256'(tbl[i].e_count));
            chk($sformatf("vec%0d.state", i),    256'(state),        256'(tbl[i].e_state));
            chk($sformatf("vec%0d.rd_valid", i), 256'(bus.rd_valid), 256'(tbl[i].e_rdv));
            chk($sformatf("vec%0d.overflow", i), 256'(overflow),     256'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.drop_cnt", i), 256'(drop_cnt),     256'(tbl[i].e_drop));
            if (tbl[i].e_rdv) begin
                chk($sformatf("vec%0d.pc", i), 256'(bus.rd_rec.pc), 256'(tbl[i].e_pc));
                chk($sformatf("vec%0d.ts", i), 256'(bus.rd_rec.ts), 256'(tbl[i].e_ts));
            end
        end

        // FIFO full with same-cycle pop: push accepted, no overflow
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 32'h1F0 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        chk("fullpop.pre_count", 256'(count), 256'(4));
        cyc(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        chk("fullpop.count",    256'(count),         256'(4));
        chk("fullpop.overflow", 256'(overflow),      256'(0));
        chk("fullpop.head",     256'(bus.rd_rec.pc), 256'(32'h1F4));
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fullpop.drain%0d", i), 256'(bus.rd_rec.pc), 256'(32'h1F4 + 32'(4 * i)));
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end

        // Ring with trigger at k=5, POST_TRIG=2
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'h300 + 32'(4 * k), k == 5, 1'b0, 1'b0);
            chk($sformatf("ring.k%0d.state", k), 256'(state),
                256'((k < 5) ? CAPTURE : (k < 7) ? POST : DONE));
            chk($sformatf("ring.k%0d.rd_valid", k), 256'(bus.rd_valid), 256'(k >= 7));
            chk($sformatf("ring.k%0d.count", k), 256'(count), 256'((k < 3) ? k + 1 : 4));
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ring.drain%0d", j), 256'(bus.rd_rec.pc), 256'(32'h300 + 32'(4 * (4 + j))));
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        chk("ring.empty", 256'(bus.rd_valid), 256'(0));

        // Ring: stop and trig together, stop-cycle event dropped
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h408, 1'b1, 1'b1, 1'b0);
        chk("stoptrig.state", 256'(state), 256'(DONE));
        chk("stoptrig.count", 256'(count), 256'(2));
        cyc(1'b0, 1'b1, 1'b1, 32'h40C, 1'b0, 1'b0, 1'b0);
        chk("stoptrig.done_count", 256'(count),         256'(2));
        chk("stoptrig.head",       256'(bus.rd_rec.pc), 256'(32'h400));

        // Re-arm during POST switches to FIFO and restarts ts
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h504, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h508, 1'b0, 1'b0, 1'b0);
        chk("rearm.in_post", 256'(state), 256'(POST));
        cyc(1'b1, 1'b0, 1'b1, 32'h50C, 1'b0, 1'b0, 1'b0);
        chk("rearm.state",    256'(state),        256'(CAPTURE));
        chk("rearm.count",    256'(count),        256'(0));
        chk("rearm.rd_valid", 256'(bus.rd_valid), 256'(0));
        cyc(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        chk("rearm.fifo_rdv", 256'(bus.rd_valid),   256'(1));
        chk("rearm.ts0",      256'(bus.rd_rec.ts),  256'(0));
        chk("rearm.pc",       256'(bus.rd_rec.pc),  256'(32'h600));
        cyc(1'b0, 1'b0, 1'b1, 32'h604, 1'b1, 1'b0, 1'b0);
        chk("rearm.trig_ignored", 256'(state), 256'(CAPTURE));
        chk("rearm.count2",       256'(count), 256'(2));

        // Drop counter saturation: 4 stored, 16 dropped -> 15
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        chk("sat.drop_cnt", 256'(drop_cnt), 256'(15));
        chk("sat.overflow", 256'(overflow), 256'(1));
        chk("sat.count",    256'(count),    256'(4));

        // Asynchronous reset mid-capture, between clock edges
        #2;
        reset = 1'b1;
        #1;
        chk("areset.state",    256'(state),        256'(IDLE));
        chk("areset.count",    256'(count),        256'(0));
        chk("areset.rd_valid", 256'(bus.rd_valid), 256'(0));
        chk("areset.overflow", 256'(overflow),     256'(0));
        chk("areset.drop_cnt", 256'(drop_cnt),     256'(0));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        #1;

        // Random stimulus against the model
        for (int unsigned n = 0; n < 3000; n++) begin
            bus.arm      = ($urandom_range(0, 49) == 0);
            bus.mode     = 1'($urandom_range(0, 1));
            bus.valid    = 1'($urandom_range(0, 1));
            bus.pc       = $urandom;
            bus.inst     = $urandom;
            bus.rdv      = ($urandom_range(0, 2) == 0);
            bus.rd_m     = 5'($urandom);
            bus.rd_data  = $urandom;
            bus.pcv      = ($urandom_range(0, 3) == 0);
            bus.pc_x     = $urandom;
            bus.trig     = ($urandom_range(0, 15) == 0);
            bus.stop     = ($urandom_range(0, 99) == 0);
            bus.rd_ready = 1'($urandom_range(0, 1));
            m_update();
            @(posedge clk);
            #1;
            compare_model(n);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
